// File: rtl/datapath_pkg.sv
// Shared widths, ALU opcodes and the Z register layout for the datapath.
package datapath_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_GPR = 16;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned SH_W    = $clog2(WIDTH);
  localparam int unsigned IMM_W   = 19;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD  = 5'b00011;
  localparam op_t OP_SUB  = 5'b00100;
  localparam op_t OP_AND  = 5'b00101;
  localparam op_t OP_OR   = 5'b00110;
  localparam op_t OP_ROR  = 5'b00111;
  localparam op_t OP_ROL  = 5'b01000;
  localparam op_t OP_SHR  = 5'b01001;
  localparam op_t OP_SHRA = 5'b01010;
  localparam op_t OP_SHL  = 5'b01011;
  localparam op_t OP_MUL  = 5'b01111;
  localparam op_t OP_DIV  = 5'b10000;
  localparam op_t OP_NEG  = 5'b10001;
  localparam op_t OP_NOT  = 5'b10010;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } zreg_t;

  // Sign-extended immediate field of the instruction register
  function automatic logic [WIDTH-1:0] sext_imm(input logic [WIDTH-1:0] ir);
    return WIDTH'($signed(ir[IMM_W-1:0]));
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: (A, B, op) -> 64-bit Zhigh:Zlow result.
// MUL/DIV hardware exists only when DATAPATH_MULDIV_EN is defined.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output zreg_t            result
);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

`ifdef DATAPATH_MULDIV_EN
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   quo;
  logic signed [WIDTH-1:0]   rem;
  assign prod = $signed(a) * $signed(b);
  assign quo  = (b == '0) ? '1 : $signed(a) / $signed(b);
  assign rem  = (b == '0) ? $signed(a) : $signed(a) % $signed(b);
`endif

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result.lo = a + b;
      OP_SUB:  result.lo = a - b;
      OP_AND:  result.lo = a & b;
      OP_OR:   result.lo = a | b;
      OP_ROR:  result.lo = (a >> sh) | (a << (WIDTH'(WIDTH) - WIDTH'(sh)));
      OP_ROL:  result.lo = (a << sh) | (a >> (WIDTH'(WIDTH) - WIDTH'(sh)));
      OP_SHR:  result.lo = a >> sh;
      OP_SHRA: result.lo = WIDTH'($signed(a) >>> sh);
      OP_SHL:  result.lo = a << sh;
`ifdef DATAPATH_MULDIV_EN
      OP_MUL:  result = zreg_t'(prod);
      OP_DIV:  result = '{hi: WIDTH'(rem), lo: WIDTH'(quo)};
`endif
      OP_NEG:  result.lo = WIDTH'(0) - b;
      OP_NOT:  result.lo = ~b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: GPRs, PC, IR, MAR, MDR, Y, Z and ALU, strobe-driven.
// Optional MUL/DIV via DATAPATH_MULDIV_EN (see datapath_alu).
module datapath
  import datapath_pkg::*;
(
  input  logic             Clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             Read,
  input  logic             write,
  input  logic R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
  input  logic R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             Yin,
  input  logic             PCout,
  input  logic             MDRout,
  input  logic             Zlowout,
  input  logic             CSignout,
  input  logic             ZMuxOut,
  input  logic             ZMuxEnbale,
  input  logic             ZSelect,
  input  logic             Zin,
  input  logic             IncPC,
  input  logic             aluin,
  input  op_t              aluControl,
  input  logic             AND,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0]   gpr [NUM_GPR];
  logic [WIDTH-1:0]   pc, ir, mar, mdr, y, bus;
  zreg_t              z, alu_res;
  logic [NUM_GPR-1:0] r_in, r_out;
  op_t                op_sel;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  assign op_sel = AND ? OP_AND : aluControl;

  datapath_alu u_alu (
    .a      (y),
    .b      (bus),
    .op     (op_sel),
    .result (alu_res)
  );

  // Shared bus; the descending loop leaves the lowest-index GPR in control
  always_comb begin
    bus = '0;
    if (ZMuxOut && ZMuxEnbale) bus = ZSelect ? z.hi : z.lo;
    else if (Zlowout)          bus = z.lo;
    else if (MDRout)           bus = mdr;
    else if (PCout)            bus = pc;
    else if (CSignout)         bus = sext_imm(ir);
    else begin
      for (int i = NUM_GPR - 1; i >= 0; i--) begin
        if (r_out[i]) bus = gpr[i];
      end
    end
  end

  assign out = bus;

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (r_in[i]) gpr[i] <= bus;
      end
    end
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      z   <= '0;
    end else begin
      if (PCin)  pc  <= bus;
      if (IRin)  ir  <= bus;
      if (MARin) mar <= bus;
      if (MDRin) mdr <= Read ? Mdatain : bus;
      if (Yin)   y   <= bus;
      if (Zin && IncPC) z <= '{hi: '0, lo: bus + WIDTH'(1)};
      else if (aluin)   z <= alu_res;
      else if (Zin)     z <= '{hi: '0, lo: bus};
    end
  end

  // MAR, the write strobe and the upper IR bits leave the block only via memory/control
  logic unused_sigs;
  assign unused_sigs = ^{write, mar, ir[WIDTH-1:IMM_W]};

endmodule

// File: tb/tb_datapath.sv
// Directed plus randomized checks of datapath against a register-transfer model.
module tb_datapath;
  import datapath_pkg::*;

  logic        Clock, clear, Read, write;
  logic [31:0] Mdatain;
  logic [15:0] rin, rout;
  logic        PCin, IRin, MARin, MDRin, Yin, PCout, MDRout, Zlowout, CSignout;
  logic        ZMuxOut, ZMuxEnbale, ZSelect, Zin, IncPC, aluin, AND;
  logic [4:0]  aluControl;
  logic [31:0] out;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_gpr [16];
  logic [31:0] m_pc, m_ir, m_mdr, m_y;
  logic [63:0] m_z;

  datapath dut (
    .Clock(Clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .write(write),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .CSignout(CSignout),
    .ZMuxOut(ZMuxOut), .ZMuxEnbale(ZMuxEnbale), .ZSelect(ZSelect),
    .Zin(Zin), .IncPC(IncPC), .aluin(aluin), .aluControl(aluControl),
    .AND(AND), .out(out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rin = '0; rout = '0; Read = 0; write = 0;
    {PCin, IRin, MARin, MDRin, Yin, PCout, MDRout, Zlowout, CSignout} = '0;
    {ZMuxOut, ZMuxEnbale, ZSelect, Zin, IncPC, aluin, AND} = '0;
    aluControl = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  function automatic logic [31:0] sext19(input logic [31:0] v);
    return v[18] ? (v | 32'hFFF8_0000) : (v & 32'h0007_FFFF);
  endfunction

  // Reference ALU from the operation definitions
  function automatic logic [63:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
    logic [31:0] t;
    int n;
    longint p;
    int sa, sb, q, r;
    n = int'(b[4:0]);
    t = a;
    sa = int'(a);
    sb = int'(b);
    case (op)
      5'd3:  return {32'h0, a + b};
      5'd4:  return {32'h0, a - b};
      5'd5:  return {32'h0, a & b};
      5'd6:  return {32'h0, a | b};
      5'd7:  begin for (int i = 0; i < n; i++) t = {t[0], t[31:1]}; return {32'h0, t}; end
      5'd8:  begin for (int i = 0; i < n; i++) t = {t[30:0], t[31]}; return {32'h0, t}; end
      5'd9:  return {32'h0, a >> n};
      5'd10: return {32'h0, 32'(sa >>> n)};
      5'd11: return {32'h0, a << n};
`ifdef DATAPATH_MULDIV_EN
      5'd15: begin p = longint'(sa) * longint'(sb); return 64'(p); end
      5'd16: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
`endif
      5'd17: return {32'h0, -b};
      5'd18: return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  // Bus value implied by a driver combination, from the priority rules
  function automatic logic [31:0] bus_ref(input logic zm, input logic zs, input logic zl,
                                          input logic md, input logic pco, input logic cs,
                                          input logic [15:0] ro);
    if (zm) return zs ? m_z[63:32] : m_z[31:0];
    if (zl) return m_z[31:0];
    if (md) return m_mdr;
    if (pco) return m_pc;
    if (cs) return sext19(m_ir);
    for (int i = 0; i < 16; i++) if (ro[i]) return m_gpr[i];
    return 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_gpr[i] = 32'h0;
    m_pc = 0; m_ir = 0; m_mdr = 0; m_y = 0; m_z = 0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1; tick(); m_mdr = v;
  endtask

  task automatic mdr_to_r(input int k);
    MDRout = 1; rin[k] = 1; tick(); m_gpr[k] = m_mdr;
  endtask

  task automatic set_r(input int k, input logic [31:0] v);
    load_mdr(v); mdr_to_r(k);
  endtask

  task automatic r_to_y(input int k);
    rout[k] = 1; Yin = 1; tick(); m_y = m_gpr[k];
  endtask

  task automatic alu_r(input int k, input logic [4:0] op, input logic andf);
    rout[k] = 1; aluin = 1; aluControl = op; AND = andf; tick();
    m_z = alu_ref(m_y, m_gpr[k], andf ? 5'd5 : op);
  endtask

  task automatic check_r(input string tag, input int k);
    rout[k] = 1; #1; chk(tag, 64'(out), 64'(m_gpr[k])); idle();
  endtask

  task automatic check_z(input string tag);
    logic [31:0] lo;
    ZMuxOut = 1; ZMuxEnbale = 1; ZSelect = 0; #1; lo = out;
    ZSelect = 1; #1;
    chk(tag, {out, lo}, m_z);
    idle();
  endtask

  logic [4:0]  ops [22];
  logic [31:0] a, b;
  logic [4:0]  op;
  logic        andf, zm, zs, zl, md, pco, cs;
  logic [15:0] ro;

  initial begin
    ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16,
            5'd17, 5'd18, 5'd0, 5'd1, 5'd2, 5'd12, 5'd13, 5'd14, 5'd19, 5'd31, 5'd16};
    idle();
    Mdatain = '0;
    clear = 1;
    model_clear();
    repeat (2) @(posedge Clock);
    #1;
    // Reset state observed through several bus drivers
    chk("reset_bus_idle", 64'(out), 64'h0);
    PCout = 1; #1; chk("reset_pc", 64'(out), 64'h0); idle();
    MDRout = 1; #1; chk("reset_mdr", 64'(out), 64'h0); idle();
    clear = 0;
    check_z("reset_z");
    check_r("reset_r15", 15);

    // AND via ZMux into R1
    set_r(2, 32'h12); set_r(3, 32'h14);
    r_to_y(2); alu_r(3, 5'b00101, 0);
    ZMuxOut = 1; ZMuxEnbale = 1; ZSelect = 0; rin[1] = 1; tick(); m_gpr[1] = m_z[31:0];
    rout[1] = 1; #1; chk("and_r1", 64'(out), 64'h10); idle();

    // PC increment and IR load
    PCout = 1; IncPC = 1; Zin = 1; tick(); m_z = {32'h0, m_pc + 1};
    Zlowout = 1; PCin = 1; tick(); m_pc = m_z[31:0];
    PCout = 1; #1; chk("pc_inc", 64'(out), 64'h1); idle();
    load_mdr(32'h2891_8000);
    MDRout = 1; IRin = 1; tick(); m_ir = m_mdr;
    CSignout = 1; #1; chk("ir_csign_pos", 64'(out), 64'h0001_8000); idle();

    // ADD / SUB
    alu_r(3, 5'b00011, 0); check_z("add");
    chk("add_const", m_z, 64'h26);
    alu_r(3, 5'b00100, 0); check_z("sub");
    chk("sub_const", m_z, 64'hFFFF_FFFE);

    // MUL / DIV and divide by zero
    set_r(4, 32'hFFFF_FFFF); set_r(5, 32'h2);
    r_to_y(4); alu_r(5, 5'b01111, 0); check_z("mul_neg1x2");
`ifdef DATAPATH_MULDIV_EN
    chk("mul_const", m_z, 64'hFFFF_FFFF_FFFF_FFFE);
`else
    chk("mul_off_const", m_z, 64'h0);
`endif
    set_r(6, 32'h14); set_r(7, 32'h3); set_r(8, 32'h0);
    r_to_y(6); alu_r(7, 5'b10000, 0); check_z("div_20_3");
    alu_r(8, 5'b10000, 0); check_z("div_by_zero");

    // Sign-extended constant with IR[18:0] all ones
    load_mdr(32'h0007_FFFF);
    MDRout = 1; IRin = 1; tick(); m_ir = m_mdr;
    CSignout = 1; #1; chk("csign_neg", 64'(out), 64'hFFFF_FFFF); idle();

    // Randomized ALU operations, including the AND override
    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      op = ops[$urandom_range(0, 21)];
      andf = ($urandom_range(0, 7) == 0);
      if (op == 5'd16 && t % 5 == 0) b = 0;
      if (op == 5'd16 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h1;
      set_r(9, a); set_r(10, b);
      r_to_y(9); alu_r(10, op, andf);
      check_z($sformatf("alu_rand op=%0d and=%0d", op, andf));
    end

    // Randomized bus priority across all drivers
    for (int k = 0; k < 16; k++) set_r(k, $urandom);
    r_to_y(3); alu_r(4, 5'b01111, 0);
    load_mdr($urandom);
    MDRout = 1; IRin = 1; tick(); m_ir = m_mdr;
    load_mdr($urandom);
    for (int t = 0; t < 60; t++) begin
      ZMuxOut = ($urandom_range(0, 3) == 0); ZMuxEnbale = ($urandom_range(0, 1) == 1);
      ZSelect = $urandom_range(0, 1) == 1; Zlowout = ($urandom_range(0, 4) == 0);
      MDRout = ($urandom_range(0, 4) == 0); PCout = ($urandom_range(0, 4) == 0);
      CSignout = ($urandom_range(0, 4) == 0);
      ro = (t % 7 == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
      rout = ro;
      zm = ZMuxOut & ZMuxEnbale; zs = ZSelect; zl = Zlowout; md = MDRout;
      pco = PCout; cs = CSignout;
      #1;
      chk("bus_prio", 64'(out), 64'(bus_ref(zm, zs, zl, md, pco, cs, ro)));
      idle();
    end

    // Asynchronous clear between edges
    @(posedge Clock); #2;
    clear = 1; #1;
    model_clear();
    check_r("clear_r0", 0);
    check_r("clear_r9", 9);
    PCout = 1; #1; chk("clear_pc", 64'(out), 64'h0); idle();
    MDRout = 1; #1; chk("clear_mdr", 64'(out), 64'h0); idle();
    CSignout = 1; #1; chk("clear_ir", 64'(out), 64'h0); idle();
    check_z("clear_z");
    @(posedge Clock); #1;
    clear = 0;
    r_to_y(0); alu_r(0, 5'b00011, 0); check_z("clear_y_sum");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
